// File: rtl/jtag_uart_tx_scheduler.sv
// Round-robin scheduler that shares one JTAG UART transmit FIFO among NUM_REQ byte producers.
// Polls WSPACE, tracks free entries as local credit, and writes a byte only when room is known.
module jtag_uart_tx_scheduler #(
    parameter int NUM_REQ        = 2,
    parameter int BACKOFF_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 av_address,
    output logic                 av_chipselect,
    output logic                 av_read_n,
    output logic                 av_write_n,
    output logic [31:0]          av_writedata,
    input  logic [31:0]          av_readdata,
    input  logic                 av_waitrequest,
    output logic                 busy,
    output logic [15:0]          credit,
    output logic [15:0]          tx_count
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(BACKOFF_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL,
        S_BACKOFF,
        S_GRANT,
        S_WRITE
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_last;
    logic [CNT_W-1:0] r_cnt;
    logic             r_wdone;
    logic [15:0]      r_credit;
    logic [15:0]      r_tx_count;
    logic             r_cs;
    logic             r_addr;
    logic             r_rd_n;
    logic             r_wr_n;
    logic [7:0]       r_wdata;

    logic             w_any;
    logic             w_found;
    logic [IDX_W-1:0] w_pick;
    logic [7:0]       w_byte;
    logic [15:0]      w_wspace;
    logic             w_unused;

    assign w_any    = |req_valid;
    assign w_wspace = av_readdata[31:16];
    assign w_unused = &{1'b0, av_readdata[15:0]};

    // Search order starts just after the last winner, so every requester is reached within NUM_REQ grants.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        w_found = 1'b0;
        w_pick  = '0;
        w_byte  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_found && req_valid[i] && ((int'(r_last) + k) % NUM_REQ) == i) begin
                    w_found = 1'b1;
                    w_pick  = IDX_W'(i);
                    w_byte  = req_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (r_state == S_GRANT && w_found)
            req_ready[w_pick] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state    <= S_IDLE;
            r_last     <= IDX_W'(NUM_REQ - 1);
            r_cnt      <= '0;
            r_wdone    <= 1'b0;
            r_credit   <= '0;
            r_tx_count <= '0;
            r_cs       <= 1'b0;
            r_addr     <= 1'b0;
            r_rd_n     <= 1'b1;
            r_wr_n     <= 1'b1;
            r_wdata    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        if (r_credit != '0) begin
                            r_state <= S_GRANT;
                        end else begin
                            r_state <= S_POLL;
                            r_cs    <= 1'b1;
                            r_addr  <= 1'b1;
                            r_rd_n  <= 1'b0;
                        end
                    end
                end
                S_POLL: begin
                    if (!av_waitrequest) begin
                        r_credit <= w_wspace;
                        r_cs     <= 1'b0;
                        r_addr   <= 1'b0;
                        r_rd_n   <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= (w_wspace != '0) ? S_GRANT : S_BACKOFF;
                    end
                end
                S_BACKOFF: begin
                    if (!w_any) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == CNT_W'(BACKOFF_CYCLES - 1)) begin
                        r_state <= S_POLL;
                        r_cs    <= 1'b1;
                        r_addr  <= 1'b1;
                        r_rd_n  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_GRANT: begin
                    if (w_found) begin
                        r_wdata <= w_byte;
                        r_last  <= w_pick;
                        r_wdone <= 1'b0;
                        r_cs    <= 1'b1;
                        r_addr  <= 1'b0;
                        r_wr_n  <= 1'b0;
                        r_state <= S_WRITE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    if (!r_wdone) begin
                        if (!av_waitrequest) begin
                            r_credit   <= r_credit - 16'd1;
                            r_tx_count <= r_tx_count + 16'd1;
                            r_cs       <= 1'b0;
                            r_wr_n     <= 1'b1;
                            r_wdone    <= 1'b1;
                        end
                    end else if (!w_any) begin
                        r_state <= S_IDLE;
                    end else if (r_credit != '0) begin
                        r_state <= S_GRANT;
                    end else begin
                        // Credit already reflects the finished write, so zero here means re-poll.
                        r_state <= S_POLL;
                        r_cs    <= 1'b1;
                        r_addr  <= 1'b1;
                        r_rd_n  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign av_chipselect = r_cs;
    assign av_address    = r_addr;
    assign av_read_n     = r_rd_n;
    assign av_write_n    = r_wr_n;
    assign av_writedata  = {24'h0, r_wdata};
    assign busy          = (r_state != S_IDLE);
    assign credit        = r_credit;
    assign tx_count      = r_tx_count;

endmodule
